// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core.
// It tracks registers with writes still in flight, so that RAW and WAW hazards stall decode.
// It freezes the whole pipe while memory is busy, and it flushes the front end on taken branches.
// It also keeps saturating statistics of stall cycles.
//
// Memory handshake: mem_req_i is asserted while the mem stage holds a load or store.
// The access completes in the cycle where mem_req_i && mem_ready_i are both high.
// A request without ready freezes the pipe from that same cycle until the completion cycle.
// The freeze covers the completion cycle as well.
module pipeline_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs1_used_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_we_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_rd_addr_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             freeze_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             issue_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] hazard_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_e;

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 br_hold_q, br_hold_d;
  logic [NUM_REGS-1:1]  pending_q, pending_d;
  logic [CNT_W-1:0]     hazard_cnt_q, memwait_cnt_q;

  logic rs1_pend, rs2_pend, rd_pend, hazard;
  logic hz_inc, mw_inc;
  logic stall_if_c, stall_id_c, freeze_c, flush_if_c, flush_id_c, issue_c, mem_err_c;

  // Look up the pending bit of each decode operand; x0 is never tracked
  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    rd_pend  = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (id_rs1_addr_i == 5'(i)) rs1_pend = pending_q[i];
      if (id_rs2_addr_i == 5'(i)) rs2_pend = pending_q[i];
      if (id_rd_addr_i  == 5'(i)) rd_pend  = pending_q[i];
    end
    hazard = id_valid_i && ((id_rs1_used_i && rs1_pend) ||
                            (id_rs2_used_i && rs2_pend) ||
                            (id_we_i && rd_pend));
  end

  // Next-state and control outputs of the sequencing FSM
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    br_hold_d  = br_hold_q;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    freeze_c   = 1'b0;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;
    issue_c    = 1'b0;
    mem_err_c  = 1'b0;
    hz_inc     = 1'b0;
    mw_inc     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        tmo_d = '0;
        if (mem_req_i && !mem_ready_i) begin
          // Freeze starts in the request cycle; any branch waits for RUN
          state_d    = S_MEM_WAIT;
          freeze_c   = 1'b1;
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
        end else begin
          br_hold_d = 1'b0;
          if (ex_branch_taken_i || br_hold_q) begin
            flush_if_c = 1'b1;
            flush_id_c = 1'b1;
          end else if (hazard) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            hz_inc     = 1'b1;
          end else begin
            issue_c = id_valid_i;
          end
        end
      end
      S_MEM_WAIT: begin
        freeze_c   = 1'b1;
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        mw_inc     = 1'b1;
        if (ex_branch_taken_i) br_hold_d = 1'b1;
        if (mem_ready_i) begin
          state_d = S_RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ERROR: begin
        freeze_c   = 1'b1;
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        mem_err_c  = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Scoreboard update: a commit clears, an issue sets, and a set wins over a same-cycle clear
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wb_we_i && wb_rd_addr_i == 5'(i)) pending_d[i] = 1'b0;
      if (issue_c && id_we_i && id_rd_addr_i == 5'(i)) pending_d[i] = 1'b1;
    end
  end

  // State, timeout, held-branch and scoreboard registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_RUN;
      tmo_q     <= '0;
      br_hold_q <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      br_hold_q <= br_hold_d;
      pending_q <= pending_d;
    end
  end

  // Saturating stall statistics
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hazard_cnt_q  <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (hz_inc && hazard_cnt_q != '1)  hazard_cnt_q  <= hazard_cnt_q + 1'b1;
      if (mw_inc && memwait_cnt_q != '1) memwait_cnt_q <= memwait_cnt_q + 1'b1;
    end
  end

  // Controls are forced low while reset is asserted
  assign stall_if_o    = rstn_i & stall_if_c;
  assign stall_id_o    = rstn_i & stall_id_c;
  assign freeze_o      = rstn_i & freeze_c;
  assign flush_if_o    = rstn_i & flush_if_c;
  assign flush_id_o    = rstn_i & flush_id_c;
  assign issue_o       = rstn_i & issue_c;
  assign mem_err_o     = rstn_i & mem_err_c;
  assign hazard_cnt_o  = hazard_cnt_q;
  assign memwait_cnt_o = memwait_cnt_q;
  assign state_o       = state_q;

endmodule
